// File: rtl/pu_or1k_pcu_evgen.sv
// Performance-counter event conditioning.
// Turns raw fetch, LSU, cache/MMU miss and stall status into eleven registered
// single-cycle strobes. Each strobe is its raw condition masked by the qualifier
// (no debug halt, no pipeline flush), registered once.
//
// LSU tracker states:
//   state     | meaning
//   ----------+----------------------------------------------------------
//   LSU_IDLE  | no access outstanding; a new issue is accepted here
//   LSU_WAIT  | access issued without ack; every cycle here is a stall
//
// The branch-stall raw condition is taken from the counter's next value, so a
// mispredict in cycle t produces a stall strobe starting at t+1 and lasting
// BRANCH_PENALTY cycles. A back-to-back mispredict reloads the count.
module pu_or1k_pcu_evgen #(
    parameter string FEATURE_DCACHE = "ENABLED",
    parameter string FEATURE_ICACHE = "ENABLED",
    parameter string FEATURE_DMMU   = "ENABLED",
    parameter string FEATURE_IMMU   = "ENABLED",
    parameter int    BRANCH_PENALTY = 2
) (
    input  logic clk,
    input  logic rst,

    input  logic du_stall_i,
    input  logic pipeline_flush_i,

    input  logic ifetch_req_i,
    input  logic ifetch_ack_i,

    input  logic lsu_valid_i,
    input  logic lsu_load_i,
    input  logic lsu_store_i,
    input  logic lsu_ack_i,

    input  logic dcache_miss_i,
    input  logic icache_miss_i,
    input  logic dtlb_miss_i,
    input  logic itlb_miss_i,

    input  logic branch_mispredict_i,
    input  logic datadep_stall_i,

    output logic pcu_event_load_o,
    output logic pcu_event_store_o,
    output logic pcu_event_ifetch_o,
    output logic pcu_event_dcache_miss_o,
    output logic pcu_event_icache_miss_o,
    output logic pcu_event_ifetch_stall_o,
    output logic pcu_event_lsu_stall_o,
    output logic pcu_event_brn_stall_o,
    output logic pcu_event_dtlb_miss_o,
    output logic pcu_event_itlb_miss_o,
    output logic pcu_event_datadep_stall_o
);

    localparam logic [3:0] BRN_LOAD = 4'(BRANCH_PENALTY);

    localparam logic DC_EN  = (FEATURE_DCACHE != "NONE");
    localparam logic IC_EN  = (FEATURE_ICACHE != "NONE");
    localparam logic DMMU_EN = (FEATURE_DMMU != "NONE");
    localparam logic IMMU_EN = (FEATURE_IMMU != "NONE");

    // Event vector bit positions.
    localparam int E_LOAD   = 10;
    localparam int E_STORE  = 9;
    localparam int E_IFETCH = 8;
    localparam int E_DCM    = 7;
    localparam int E_ICM    = 6;
    localparam int E_IFSTL  = 5;
    localparam int E_LSUSTL = 4;
    localparam int E_BRN    = 3;
    localparam int E_DTLB   = 2;
    localparam int E_ITLB   = 1;
    localparam int E_DDEP   = 0;

    typedef enum logic {
        LSU_IDLE = 1'b0,
        LSU_WAIT = 1'b1
    } lsu_state_t;

    logic qual;
    assign qual = ~du_stall_i & ~pipeline_flush_i;

    // ------------------------------------------------------------------
    // Miss edge detectors; the sampling register is only built when the
    // feature exists. It samples every cycle, so a rise hidden by the
    // qualifier is consumed and never counted later.
    // ------------------------------------------------------------------
    logic dcm_raw;
    logic icm_raw;
    logic dtlb_raw;
    logic itlb_raw;

    generate
        if (DC_EN) begin : g_dcm_on
            logic dcm_q;
            // Previous-cycle dcache miss level.
            always_ff @(posedge clk) begin
                if (rst) dcm_q <= 1'b0;
                else     dcm_q <= dcache_miss_i;
            end
            assign dcm_raw = dcache_miss_i & ~dcm_q;
        end else begin : g_dcm_off
            logic unused_dcm;
            assign unused_dcm = dcache_miss_i;
            assign dcm_raw    = 1'b0;
        end

        if (IC_EN) begin : g_icm_on
            logic icm_q;
            // Previous-cycle icache miss level.
            always_ff @(posedge clk) begin
                if (rst) icm_q <= 1'b0;
                else     icm_q <= icache_miss_i;
            end
            assign icm_raw = icache_miss_i & ~icm_q;
        end else begin : g_icm_off
            logic unused_icm;
            assign unused_icm = icache_miss_i;
            assign icm_raw    = 1'b0;
        end

        if (DMMU_EN) begin : g_dtlb_on
            logic dtlb_q;
            // Previous-cycle DTLB miss level.
            always_ff @(posedge clk) begin
                if (rst) dtlb_q <= 1'b0;
                else     dtlb_q <= dtlb_miss_i;
            end
            assign dtlb_raw = dtlb_miss_i & ~dtlb_q;
        end else begin : g_dtlb_off
            logic unused_dtlb;
            assign unused_dtlb = dtlb_miss_i;
            assign dtlb_raw    = 1'b0;
        end

        if (IMMU_EN) begin : g_itlb_on
            logic itlb_q;
            // Previous-cycle ITLB miss level.
            always_ff @(posedge clk) begin
                if (rst) itlb_q <= 1'b0;
                else     itlb_q <= itlb_miss_i;
            end
            assign itlb_raw = itlb_miss_i & ~itlb_q;
        end else begin : g_itlb_off
            logic unused_itlb;
            assign unused_itlb = itlb_miss_i;
            assign itlb_raw    = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // LSU transfer tracker
    // ------------------------------------------------------------------
    lsu_state_t lsu_state_q, lsu_state_d;
    logic       is_store_q, is_store_d;
    logic       lsu_load_raw;
    logic       lsu_store_raw;
    logic       lsu_stall_raw;

    // LSU state and pending-access type registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            lsu_state_q <= LSU_IDLE;
            is_store_q  <= 1'b0;
        end else begin
            lsu_state_q <= lsu_state_d;
            is_store_q  <= is_store_d;
        end
    end

    // LSU next state and raw load/store/stall conditions; store wins if both
    // type bits are set, and a flush always abandons the outstanding access.
    always_comb begin
        lsu_state_d   = lsu_state_q;
        is_store_d    = is_store_q;
        lsu_load_raw  = 1'b0;
        lsu_store_raw = 1'b0;
        lsu_stall_raw = 1'b0;
        case (lsu_state_q)
            LSU_IDLE: begin
                if (lsu_valid_i & (lsu_load_i | lsu_store_i)) begin
                    if (lsu_ack_i) begin
                        lsu_store_raw = lsu_store_i;
                        lsu_load_raw  = ~lsu_store_i;
                    end else begin
                        is_store_d  = lsu_store_i;
                        lsu_state_d = LSU_WAIT;
                    end
                end
            end
            LSU_WAIT: begin
                if (lsu_ack_i) begin
                    lsu_store_raw = is_store_q;
                    lsu_load_raw  = ~is_store_q;
                    lsu_state_d   = LSU_IDLE;
                end else begin
                    lsu_stall_raw = 1'b1;
                end
            end
            default: lsu_state_d = LSU_IDLE;
        endcase
        if (pipeline_flush_i) lsu_state_d = LSU_IDLE;
    end

    // ------------------------------------------------------------------
    // Branch penalty down-counter
    // ------------------------------------------------------------------
    logic [3:0] brn_cnt_q, brn_cnt_d;

    // Branch penalty counter register.
    always_ff @(posedge clk) begin
        if (rst) brn_cnt_q <= 4'd0;
        else     brn_cnt_q <= brn_cnt_d;
    end

    // Debug halt freezes the count entirely; a mispredict reloads, else count down.
    always_comb begin
        brn_cnt_d = brn_cnt_q;
        if (du_stall_i) begin
            brn_cnt_d = brn_cnt_q;
        end else if (branch_mispredict_i) begin
            brn_cnt_d = BRN_LOAD;
        end else if (brn_cnt_q != 4'd0) begin
            brn_cnt_d = brn_cnt_q - 4'd1;
        end
    end

    // ------------------------------------------------------------------
    // Qualified, registered event strobes
    // ------------------------------------------------------------------
    logic [10:0] evt_raw;
    logic [10:0] evt_d;
    logic [10:0] evt_q;

    // Gather raw conditions and apply the halt/flush qualifier.
    always_comb begin
        evt_raw           = '0;
        evt_raw[E_LOAD]   = lsu_load_raw;
        evt_raw[E_STORE]  = lsu_store_raw;
        evt_raw[E_IFETCH] = ifetch_req_i & ifetch_ack_i;
        evt_raw[E_DCM]    = dcm_raw;
        evt_raw[E_ICM]    = icm_raw;
        evt_raw[E_IFSTL]  = ifetch_req_i & ~ifetch_ack_i;
        evt_raw[E_LSUSTL] = lsu_stall_raw;
        evt_raw[E_BRN]    = (brn_cnt_d != 4'd0);
        evt_raw[E_DTLB]   = dtlb_raw;
        evt_raw[E_ITLB]   = itlb_raw;
        evt_raw[E_DDEP]   = datadep_stall_i;
        evt_d             = evt_raw & {11{qual}};
    end

    // Output strobe register.
    always_ff @(posedge clk) begin
        if (rst) evt_q <= '0;
        else     evt_q <= evt_d;
    end

    assign pcu_event_load_o          = evt_q[E_LOAD];
    assign pcu_event_store_o         = evt_q[E_STORE];
    assign pcu_event_ifetch_o        = evt_q[E_IFETCH];
    assign pcu_event_dcache_miss_o   = DC_EN & evt_q[E_DCM];
    assign pcu_event_icache_miss_o   = IC_EN & evt_q[E_ICM];
    assign pcu_event_ifetch_stall_o  = evt_q[E_IFSTL];
    assign pcu_event_lsu_stall_o     = evt_q[E_LSUSTL];
    assign pcu_event_brn_stall_o     = evt_q[E_BRN];
    assign pcu_event_dtlb_miss_o     = DMMU_EN & evt_q[E_DTLB];
    assign pcu_event_itlb_miss_o     = IMMU_EN & evt_q[E_ITLB];
    assign pcu_event_datadep_stall_o = evt_q[E_DDEP];

endmodule

// File: tb/tb_pu_or1k_pcu_evgen.sv
// Bench for pu_or1k_pcu_evgen: directed scenarios plus random traffic, all
// checked every cycle against a behavioural model, on a full-feature instance
// and on an instance with all cache/MMU features removed.
module tb_pu_or1k_pcu_evgen;

    logic clk;
    logic rst, du, fl, req, ifa, lv, ll, ls, la, dc, ic, dt, it, mp, dd;

    logic [10:0] dvec;   // full-feature instance
    logic [10:0] nvec;   // no-feature instance

    int total = 0;
    int bad   = 0;

    // Model state
    logic       m_dc, m_ic, m_dt, m_it;
    logic       m_pend, m_pst;
    int         m_cnt;
    logic [10:0] exp_vec;

    int c_ld, c_st, c_if, c_ifs, c_lstl, c_dcm, c_brn;

    localparam int PEN = 2;

    pu_or1k_pcu_evgen #(.BRANCH_PENALTY(PEN)) u_dut (
        .clk(clk), .rst(rst),
        .du_stall_i(du), .pipeline_flush_i(fl),
        .ifetch_req_i(req), .ifetch_ack_i(ifa),
        .lsu_valid_i(lv), .lsu_load_i(ll), .lsu_store_i(ls), .lsu_ack_i(la),
        .dcache_miss_i(dc), .icache_miss_i(ic), .dtlb_miss_i(dt), .itlb_miss_i(it),
        .branch_mispredict_i(mp), .datadep_stall_i(dd),
        .pcu_event_load_o(dvec[10]), .pcu_event_store_o(dvec[9]),
        .pcu_event_ifetch_o(dvec[8]), .pcu_event_dcache_miss_o(dvec[7]),
        .pcu_event_icache_miss_o(dvec[6]), .pcu_event_ifetch_stall_o(dvec[5]),
        .pcu_event_lsu_stall_o(dvec[4]), .pcu_event_brn_stall_o(dvec[3]),
        .pcu_event_dtlb_miss_o(dvec[2]), .pcu_event_itlb_miss_o(dvec[1]),
        .pcu_event_datadep_stall_o(dvec[0])
    );

    pu_or1k_pcu_evgen #(
        .FEATURE_DCACHE("NONE"), .FEATURE_ICACHE("NONE"),
        .FEATURE_DMMU("NONE"), .FEATURE_IMMU("NONE"),
        .BRANCH_PENALTY(PEN)
    ) u_dis (
        .clk(clk), .rst(rst),
        .du_stall_i(du), .pipeline_flush_i(fl),
        .ifetch_req_i(req), .ifetch_ack_i(ifa),
        .lsu_valid_i(lv), .lsu_load_i(ll), .lsu_store_i(ls), .lsu_ack_i(la),
        .dcache_miss_i(dc), .icache_miss_i(ic), .dtlb_miss_i(dt), .itlb_miss_i(it),
        .branch_mispredict_i(mp), .datadep_stall_i(dd),
        .pcu_event_load_o(nvec[10]), .pcu_event_store_o(nvec[9]),
        .pcu_event_ifetch_o(nvec[8]), .pcu_event_dcache_miss_o(nvec[7]),
        .pcu_event_icache_miss_o(nvec[6]), .pcu_event_ifetch_stall_o(nvec[5]),
        .pcu_event_lsu_stall_o(nvec[4]), .pcu_event_brn_stall_o(nvec[3]),
        .pcu_event_dtlb_miss_o(nvec[2]), .pcu_event_itlb_miss_o(nvec[1]),
        .pcu_event_datadep_stall_o(nvec[0])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Expected strobes for the coming edge, from the current inputs.
    task automatic model_update();
        logic q, ld_ev, st_ev, stl;
        if (rst) begin
            exp_vec = '0;
            m_dc = 1'b0; m_ic = 1'b0; m_dt = 1'b0; m_it = 1'b0;
            m_pend = 1'b0; m_pst = 1'b0; m_cnt = 0;
            return;
        end
        q     = !du && !fl;
        ld_ev = 1'b0;
        st_ev = 1'b0;
        stl   = 1'b0;
        // LSU: one event per completed transfer, one stall per waiting cycle.
        if (!m_pend) begin
            if (lv && (ll || ls)) begin
                if (la) begin
                    if (ls) st_ev = 1'b1;
                    else    ld_ev = 1'b1;
                end else if (!fl) begin
                    m_pend = 1'b1;
                    m_pst  = ls;
                end
            end
        end else begin
            if (la) begin
                if (m_pst) st_ev = 1'b1;
                else       ld_ev = 1'b1;
                m_pend = 1'b0;
            end else begin
                stl = 1'b1;
            end
            if (fl) m_pend = 1'b0;
        end
        // Branch: remaining penalty cycles, frozen by debug halt.
        if (!du) begin
            if (mp)             m_cnt = PEN;
            else if (m_cnt > 0) m_cnt = m_cnt - 1;
        end
        exp_vec = {ld_ev, st_ev, req && ifa, dc && !m_dc, ic && !m_ic,
                   req && !ifa, stl, m_cnt != 0, dt && !m_dt, it && !m_it, dd};
        if (!q) exp_vec = '0;
        m_dc = dc; m_ic = ic; m_dt = dt; m_it = it;
    endtask

    task automatic step();
        logic [10:0] nexp;
        model_update();
        @(posedge clk);
        #1;
        nexp = exp_vec & 11'b111_0011_1001;
        chk("evt_full", 32'(dvec), 32'(exp_vec));
        chk("evt_nofeat", 32'(nvec), 32'(nexp));
        c_ld   += int'(dvec[10]);
        c_st   += int'(dvec[9]);
        c_if   += int'(dvec[8]);
        c_dcm  += int'(dvec[7]);
        c_ifs  += int'(dvec[5]);
        c_lstl += int'(dvec[4]);
        c_brn  += int'(dvec[3]);
    endtask

    task automatic idle();
        rst = 0; du = 0; fl = 0; req = 0; ifa = 0; lv = 0; ll = 0; ls = 0; la = 0;
        dc = 0; ic = 0; dt = 0; it = 0; mp = 0; dd = 0;
    endtask

    task automatic clr_cnt();
        c_ld = 0; c_st = 0; c_if = 0; c_ifs = 0; c_lstl = 0; c_dcm = 0; c_brn = 0;
    endtask

    initial begin
        int r;
        idle();
        clr_cnt();
        rst = 1;
        step();
        step();
        chk("reset_outputs", 32'(dvec), 32'd0);
        idle();
        step();

        // Fetch: req for 4 cycles, ack only in the 4th.
        clr_cnt();
        req = 1;
        for (int i = 0; i < 3; i++) step();
        ifa = 1;
        step();
        idle();
        step();
        step();
        chk("fetch_stall_n", 32'(c_ifs), 32'd3);
        chk("fetch_n", 32'(c_if), 32'd1);

        // Load waiting three cycles, then store with same-cycle ack.
        clr_cnt();
        lv = 1; ll = 1;
        step();
        idle();
        for (int i = 0; i < 3; i++) step();
        la = 1;
        step();
        idle();
        step();
        chk("lsu_stall_n", 32'(c_lstl), 32'd3);
        chk("load_n", 32'(c_ld), 32'd1);
        clr_cnt();
        lv = 1; ls = 1; la = 1;
        step();
        idle();
        step();
        chk("store_n", 32'(c_st), 32'd1);
        chk("store_stall_n", 32'(c_lstl), 32'd0);

        // Miss edges: two rises -> two pulses; first rise under halt -> one.
        clr_cnt();
        dc = 1;
        for (int i = 0; i < 5; i++) step();
        dc = 0; step();
        dc = 1; step();
        dc = 0; step(); step();
        chk("dcm_n", 32'(c_dcm), 32'd2);
        clr_cnt();
        du = 1; dc = 1; step();
        du = 0;
        for (int i = 0; i < 4; i++) step();
        dc = 0; step();
        dc = 1; step();
        dc = 0; step(); step();
        chk("dcm_halt_n", 32'(c_dcm), 32'd1);

        // Back-to-back mispredicts reload rather than add.
        clr_cnt();
        mp = 1; step(); step();
        mp = 0;
        for (int i = 0; i < 4; i++) step();
        chk("brn_n", 32'(c_brn), 32'd3);

        // Flush while waiting, ack in the same cycle: nothing counted.
        clr_cnt();
        lv = 1; ll = 1; step();
        idle(); fl = 1; la = 1; step();
        idle(); step();
        chk("flush_load_n", 32'(c_ld), 32'd0);
        lv = 1; ll = 1; la = 1; step();
        idle(); step();
        chk("post_flush_load_n", 32'(c_ld), 32'd1);

        // Reset in the middle of a wait drops the pending access.
        clr_cnt();
        lv = 1; ls = 1; dd = 1; req = 1; step();
        idle(); rst = 1; la = 1; dd = 1; req = 1; mp = 1; step();
        chk("rst_mid_wait", 32'(dvec), 32'd0);
        idle(); la = 1; step();
        idle(); step();
        chk("rst_drop_store", 32'(c_st), 32'd0);

        // Random traffic.
        idle();
        for (int n = 0; n < 4000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            du  = ($urandom_range(0, 9) == 0);
            fl  = ($urandom_range(0, 11) == 0);
            req = ($urandom_range(0, 1) == 1);
            ifa = ($urandom_range(0, 2) == 0);
            lv  = ($urandom_range(0, 1) == 1);
            r   = int'($urandom_range(0, 9));
            ll  = (r < 4) || (r == 9);
            ls  = (r >= 4 && r < 8) || (r == 9);
            la  = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) dc = ~dc;
            if ($urandom_range(0, 3) == 0) ic = ~ic;
            if ($urandom_range(0, 3) == 0) dt = ~dt;
            if ($urandom_range(0, 3) == 0) it = ~it;
            mp  = ($urandom_range(0, 9) == 0);
            dd  = ($urandom_range(0, 1) == 1);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
